// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its control/branch logic and instruction memory.
// The master side is the sequencer itself; the slave side is whoever consumes its outputs.
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   stall;
    logic                   branch_taken;
    logic [ADDR_WIDTH-1:0]  branch_target;
    logic [ADDR_WIDTH-1:0]  readAddress;
    logic                   fetch_en;
    logic                   instr_valid;
    logic                   commit;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        input  stall, branch_taken, branch_target,
        output readAddress, fetch_en, instr_valid, commit, halted, instr_count
    );

    modport slave (
        output stall, branch_taken, branch_target,
        input  readAddress, fetch_en, instr_valid, commit, halted, instr_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Owns the PC and the per-instruction cycle budget: one fetch strobe, an execute window
// that stalls can stretch, then a commit to PC+1 or a branch target; halts off the program.
module fetch_sequencer #(
    parameter int CYCLES_PER_INSTR = 10,
    parameter int ADDR_WIDTH       = 32,
    parameter int MEM_DEPTH        = 11,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam int CNT_W = (CYCLES_PER_INSTR > 2) ? $clog2(CYCLES_PER_INSTR) : 1;
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(CYCLES_PER_INSTR - 2);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   fetch_en_q;
    logic                   halted_q;
    logic                   commitNow;
    logic [ADDR_WIDTH-1:0]  nextPc;

    // FETCH with fetch_en_q low only occurs straight out of reset: that first edge raises the strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        count_d   = count_q;
        commitNow = 1'b0;
        nextPc    = bus.branch_taken ? bus.branch_target : pc_q + 1'b1;
        case (state_q)
            FETCH: begin
                if (fetch_en_q) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end
            end
            EXEC: begin
                if (!bus.stall) begin
                    if (cnt_q == LAST_CNT) begin
                        commitNow = 1'b1;
                        pc_d      = nextPc;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                        state_d = (nextPc >= DEPTH_A) ? HALT : FETCH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            cnt_q      <= '0;
            pc_q       <= '0;
            count_q    <= '0;
            fetch_en_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            fetch_en_q <= (state_d == FETCH);
            halted_q   <= (state_d == HALT);
        end
    end

    assign bus.readAddress = pc_q;
    assign bus.fetch_en    = fetch_en_q;
    assign bus.instr_valid = (state_q == EXEC);
    assign bus.commit      = commitNow;
    assign bus.halted      = halted_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus a randomized run, each cycle compared against an instruction-level
// model of the sequencer (fetch, then N-1 unstalled execute cycles, then commit).
module tb_fetch_sequencer;
    localparam int N     = 10;
    localparam int DEPTH = 11;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fetch_sequencer_if #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) bus ();

    fetch_sequencer #(
        .CYCLES_PER_INSTR(N),
        .ADDR_WIDTH(32),
        .MEM_DEPTH(DEPTH),
        .COUNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] mPc;
    int          mCount;
    bit          mHalted;
    bit          mInFetch;
    int          mExecLeft;

    logic        obsFetch, obsValid, obsCommit, obsHalted;
    logic [31:0] obsAddr;
    logic [15:0] obsCount;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc       = '0;
        mCount    = 0;
        mHalted   = 1'b0;
        mInFetch  = 1'b1;
        mExecLeft = N - 1;
        cyc       = 0;
    endtask

    // Asserts reset asynchronously, checks outputs clear without a clock edge, releases at negedge.
    task automatic doReset();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        reset = 1'b0;
        #1;
        checkOutput("rst_fetch_en", bus.fetch_en, 0);
        checkOutput("rst_instr_valid", bus.instr_valid, 0);
        checkOutput("rst_commit", bus.commit, 0);
        checkOutput("rst_halted", bus.halted, 0);
        checkOutput("rst_readAddress", bus.readAddress, 0);
        checkOutput("rst_instr_count", bus.instr_count, 0);
        @(negedge clock);
        reset = 1'b1;
        modelReset();
    endtask

    task automatic applyStimulus(input bit st, input bit br, input logic [31:0] tgt);
        logic expFetch, expValid, expCommit;
        @(posedge clock);
        #1;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        #1;
        expFetch  = !mHalted && mInFetch;
        expValid  = !mHalted && !mInFetch;
        expCommit = expValid && !st && (mExecLeft == 1);
        obsFetch  = bus.fetch_en;
        obsValid  = bus.instr_valid;
        obsCommit = bus.commit;
        obsHalted = bus.halted;
        obsAddr   = bus.readAddress;
        obsCount  = bus.instr_count;
        checkOutput("fetch_en", obsFetch, expFetch);
        checkOutput("instr_valid", obsValid, expValid);
        checkOutput("commit", obsCommit, expCommit);
        checkOutput("halted", obsHalted, mHalted);
        checkOutput("readAddress", obsAddr, mPc);
        checkOutput("instr_count", obsCount, mCount);
        if (!mHalted) begin
            if (mInFetch) begin
                mInFetch  = 1'b0;
                mExecLeft = N - 1;
            end else if (!st) begin
                mExecLeft--;
                if (mExecLeft == 0) begin
                    if (mCount < 65535) mCount++;
                    mPc = br ? tgt : mPc + 32'd1;
                    if (mPc >= DEPTH) mHalted = 1'b1;
                    else mInFetch = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int haltRun;
        bit st, br;
        logic [31:0] tgt;

        $display("[TB] scenario 1: free-running period");
        doReset();
        for (int c = 0; c <= 20; c++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            checkOutput("t1_fetch", obsFetch, (c == 0 || c == 10 || c == 20));
            checkOutput("t1_commit", obsCommit, (c == 9 || c == 19));
            if (c % 10 == 0) checkOutput("t1_addr", obsAddr, c / 10);
        end
        checkOutput("t1_count", obsCount, 2);

        $display("[TB] scenario 2: stall stretches the window");
        doReset();
        for (int c = 0; c <= 13; c++) begin
            applyStimulus(c >= 3 && c <= 5, 1'b0, 32'd0);
            checkOutput("t2_commit", obsCommit, (c == 12));
            checkOutput("t2_fetch", obsFetch, (c == 0 || c == 13));
        end
        checkOutput("t2_addr", obsAddr, 1);

        $display("[TB] scenario 3: taken branch");
        doReset();
        for (int c = 0; c <= 10; c++) begin
            applyStimulus(1'b0, (c == 4 || c == 9), (c == 9) ? 32'd5 : 32'd7);
            checkOutput("t3_commit", obsCommit, (c == 9));
        end
        checkOutput("t3_fetch", obsFetch, 1);
        checkOutput("t3_addr", obsAddr, 5);

        $display("[TB] scenario 4: stall beats branch in commit cycle");
        doReset();
        for (int c = 0; c <= 11; c++) begin
            applyStimulus(c == 9, c == 9, 32'd7);
            checkOutput("t4_commit", obsCommit, (c == 10));
        end
        checkOutput("t4_fetch", obsFetch, 1);
        checkOutput("t4_addr", obsAddr, 1);

        $display("[TB] scenario 5a: run off the end of the program");
        doReset();
        for (int c = 0; c <= 129; c++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            checkOutput("t5_fetch", obsFetch, (c % 10 == 0 && c <= 100));
            checkOutput("t5_halted", obsHalted, (c >= 110));
        end
        checkOutput("t5_count", obsCount, 11);
        checkOutput("t5_addr", obsAddr, 11);

        $display("[TB] scenario 5b: branch out of range");
        doReset();
        for (int c = 0; c <= 12; c++) begin
            applyStimulus(1'b0, c == 9, 32'd20);
            checkOutput("t5b_halted", obsHalted, (c >= 10));
        end
        checkOutput("t5b_addr", obsAddr, 20);
        checkOutput("t5b_count", obsCount, 1);
        checkOutput("t5b_fetch", obsFetch, 0);

        $display("[TB] scenario 6: asynchronous reset mid-execute");
        doReset();
        for (int c = 0; c <= 35; c++) applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t6_pc_before", obsAddr, 3);
        checkOutput("t6_valid_before", obsValid, 1);
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t6_fetch_after", obsFetch, 1);
        checkOutput("t6_addr_after", obsAddr, 0);

        $display("[TB] random run");
        doReset();
        haltRun = 0;
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 3) == 0);
            tgt = 32'($urandom_range(0, 12));
            applyStimulus(st, br, tgt);
            if (mHalted) haltRun++;
            if (haltRun > 4 || $urandom_range(0, 499) == 0) begin
                doReset();
                haltRun = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
